// File: rtl/packer144.sv
// packer144: de-interleaves a 4-thread record into 36-bit lane words and streams the enabled lanes one per beat.
// Optional PACKER144_PARITY_EN adds a registered out_parity output (XOR of out_data).
module packer144 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_mask,
    input  logic [3:0]  f0,
    input  logic [31:0] f1,
    input  logic [3:0]  f2,
    input  logic [31:0] f3,
    input  logic [31:0] f4,
    input  logic [7:0]  f5,
    input  logic [31:0] f6,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] out_data,
    output logic [1:0]  out_lane,
    output logic        out_last,
`ifdef PACKER144_PARITY_EN
    output logic        out_parity,
`endif
    output logic [15:0] rec_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state;
    logic [3:0][35:0]  in_word;
    logic [3:0][35:0]  hold_word;
    logic [3:0]        hold_mask;
    logic              accept;
    logic              fire;
    logic [1:0]        first_lane;
    logic [1:0]        next_lane;
    logic [35:0]       nxt_data;
    logic              ld;

    // Lowest set mask bit at or above lo; lo may be 4, giving an empty search.
    function automatic logic [1:0] first_from(input logic [3:0] m, input logic [2:0] lo);
        logic [3:0] g;
        g = m & (4'b1111 << lo);
        if (g[0])      first_from = 2'd0;
        else if (g[1]) first_from = 2'd1;
        else if (g[2]) first_from = 2'd2;
        else           first_from = 2'd3;
    endfunction

    function automatic logic is_last(input logic [3:0] m, input logic [1:0] lane);
        is_last = (m & (4'b1110 << lane)) == 4'd0;
    endfunction

    always_comb begin
        in_word = '0;
        for (int k = 0; k < 4; k++) begin
            in_word[k][0] = f0[k];
            in_word[k][9] = f2[k];
            for (int j = 0; j < 8; j++) begin
                in_word[k][1 + j]  = f1[4 * j + k];
                in_word[k][10 + j] = f3[4 * j + k];
                in_word[k][18 + j] = f4[4 * j + k];
                in_word[k][28 + j] = f6[4 * j + k];
            end
            for (int j = 0; j < 2; j++) begin
                in_word[k][26 + j] = f5[4 * j + k];
            end
        end
    end

    assign in_ready = reset_n &&
                      ((state == IDLE) ||
                       ((state == SEND) && out_last && out_ready));
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    assign first_lane = first_from(in_mask, 3'd0);
    assign next_lane  = first_from(hold_mask, {1'b0, out_lane} + 3'd1);

    // A new record wins the output register over the held record.
    always_comb begin
        nxt_data = hold_word[next_lane];
        if (accept) nxt_data = in_word[first_lane];
        ld = (accept && (in_mask != 4'd0)) || (fire && !out_last);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= 2'd0;
            out_last  <= 1'b0;
            rec_count <= 16'd0;
            hold_word <= '0;
            hold_mask <= 4'd0;
        end else begin
            if (fire && out_last) rec_count <= rec_count + 16'd1;
            if (accept) begin
                hold_word <= in_word;
                hold_mask <= in_mask;
            end
            if (ld) out_data <= nxt_data;
            if (accept && (in_mask != 4'd0)) begin
                state     <= SEND;
                out_valid <= 1'b1;
                out_lane  <= first_lane;
                out_last  <= is_last(in_mask, first_lane);
            end else if (accept || (fire && out_last)) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (fire) begin
                out_lane <= next_lane;
                out_last <= is_last(hold_mask, next_lane);
            end
        end
    end

`ifdef PACKER144_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) out_parity <= 1'b0;
        else if (ld)  out_parity <= ^nxt_data;
    end
`endif

endmodule

// File: tb/tb_packer144.sv
// Scoreboard testbench for packer144: expected beats are queued at record accept
// and compared against each handshaked output beat.
module tb_packer144;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_mask = 4'd0;
    logic [3:0]  f0 = 4'd0;
    logic [31:0] f1 = 32'd0;
    logic [3:0]  f2 = 4'd0;
    logic [31:0] f3 = 32'd0;
    logic [31:0] f4 = 32'd0;
    logic [7:0]  f5 = 8'd0;
    logic [31:0] f6 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [35:0] out_data;
    logic [1:0]  out_lane;
    logic        out_last;
`ifdef PACKER144_PARITY_EN
    logic        out_parity;
`endif
    logic [15:0] rec_count;

    packer144 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .f0        (f0),
        .f1        (f1),
        .f2        (f2),
        .f3        (f3),
        .f4        (f4),
        .f5        (f5),
        .f6        (f6),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
`ifdef PACKER144_PARITY_EN
        .out_parity(out_parity),
`endif
        .rec_count (rec_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  lane;
        logic [35:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    exp_rec = 0;

    // Reference word built by walking each field's bits and routing bit b to lane b%4.
    function automatic logic [35:0] model_word(input int k);
        logic [35:0] w;
        w    = '0;
        w[0] = f0[k];
        w[9] = f2[k];
        for (int b = 0; b < 32; b++) begin
            if (b % 4 == k) begin
                w[1 + b / 4]  = f1[b];
                w[10 + b / 4] = f3[b];
                w[18 + b / 4] = f4[b];
                w[28 + b / 4] = f6[b];
            end
        end
        for (int b = 0; b < 8; b++) begin
            if (b % 4 == k) w[26 + b / 4] = f5[b];
        end
        return w;
    endfunction

    task automatic push_record(input logic [3:0] m);
        beat_t b;
        int    hi;
        hi = -1;
        for (int k = 0; k < 4; k++) if (m[k]) hi = k;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                b.lane = k[1:0];
                b.data = model_word(k);
                b.last = (k == hi);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic rand_fields();
        f0 = 4'($urandom);
        f1 = $urandom;
        f2 = 4'($urandom);
        f3 = $urandom;
        f4 = $urandom;
        f5 = 8'($urandom);
        f6 = $urandom;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 36'h0) begin
            failures++;
            $display("FAIL rst_data: got %h want 0", out_data);
        end
        checks++;
        if (out_lane !== 2'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_lane_last: got %0d/%b want 0/0", out_lane, out_last);
        end
        checks++;
        if (rec_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_count: got %0d want 0", rec_count);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_mask_zero_reset();
        beat_t e;
        @(posedge clk);
        #1;
        rand_fields();
        in_mask   = 4'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mz_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mz_no_beat: cycle %0d got out_valid=%b want 0", c, out_valid);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rec_count !== 16'(exp_rec)) begin
            failures++;
            $display("FAIL mz_count: got %0d want %0d", rec_count, exp_rec);
        end
        rand_fields();
        in_mask  = 4'hF;
        in_valid = 1'b1;
        #1;
        push_record(in_mask);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (!(out_valid && out_ready) || exp_q.size() == 0) begin
            failures++;
            $display("FAIL mz_beat1: got out_valid=%b want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if ({out_lane, out_data, out_last} !== {e.lane, e.data, e.last}) begin
                failures++;
                $display("FAIL mz_beat1: got lane=%0d data=%h last=%b want lane=%0d data=%h last=%b",
                         out_lane, out_data, out_last, e.lane, e.data, e.last);
            end
        end
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mz_rst_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || rec_count !== 16'd0) begin
            failures++;
            $display("FAIL mz_rst_state: got valid=%b count=%0d want 0/0", out_valid, rec_count);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mz_rst_ready2: got %b want 0", in_ready);
        end
        exp_q.delete();
        exp_rec = 0;
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mz_rst_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_lane_map();
        beat_t e;
        int    beats;
        int    first;
        beats = 0;
        first = -1;
        @(posedge clk);
        #1;
        f0 = 4'b0101; f1 = 32'h0; f2 = 4'h0; f3 = 32'h0;
        f4 = 32'h0;   f5 = 8'h0;  f6 = 32'hF000_0000;
        in_mask   = 4'hF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back('{2'd0, 36'h8_0000_0001, 1'b0});
        exp_q.push_back('{2'd1, 36'h8_0000_0000, 1'b0});
        exp_q.push_back('{2'd2, 36'h8_0000_0001, 1'b0});
        exp_q.push_back('{2'd3, 36'h8_0000_0000, 1'b1});
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rand_fields();
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (first < 0) first = c;
                beats++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL lm_beat: unexpected beat lane=%0d data=%h", out_lane, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_lane, out_data, out_last} !== {e.lane, e.data, e.last}) begin
                        failures++;
                        $display("FAIL lm_beat: got lane=%0d data=%h last=%b want lane=%0d data=%h last=%b",
                                 out_lane, out_data, out_last, e.lane, e.data, e.last);
                    end
`ifdef PACKER144_PARITY_EN
                    checks++;
                    if (out_parity !== ^e.data) begin
                        failures++;
                        $display("FAIL lm_parity: got %b want %b", out_parity, ^e.data);
                    end
`endif
                    if (e.last) exp_rec++;
                end
            end
        end
        checks++;
        if (beats != 4 || first != 0) begin
            failures++;
            $display("FAIL lm_count: got beats=%0d first=%0d want 4/0", beats, first);
        end
        checks++;
        if (rec_count !== 16'(exp_rec)) begin
            failures++;
            $display("FAIL lm_rec: got %0d want %0d", rec_count, exp_rec);
        end
    endtask

    task automatic test_sparse();
        beat_t e;
        int    beats;
        int    first;
        int    lastc;
        beats = 0;
        first = -1;
        lastc = -1;
        @(posedge clk);
        #1;
        f0 = 4'h0; f1 = 32'hFFFF_FFFF; f2 = 4'h0; f3 = 32'h0;
        f4 = 32'h0; f5 = 8'h0; f6 = 32'h0;
        in_mask  = 4'b1010;
        in_valid = 1'b1;
        exp_q.push_back('{2'd1, 36'h0_0000_01FE, 1'b0});
        exp_q.push_back('{2'd3, 36'h0_0000_01FE, 1'b1});
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            rand_fields();
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (first < 0) first = c;
                lastc = c;
                beats++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sp_beat: unexpected beat lane=%0d data=%h", out_lane, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_lane, out_data, out_last} !== {e.lane, e.data, e.last}) begin
                        failures++;
                        $display("FAIL sp_beat: got lane=%0d data=%h last=%b want lane=%0d data=%h last=%b",
                                 out_lane, out_data, out_last, e.lane, e.data, e.last);
                    end
                    if (e.last) exp_rec++;
                end
            end
        end
        checks++;
        if (beats != 2 || first != 0 || lastc != 1) begin
            failures++;
            $display("FAIL sp_count: got beats=%0d first=%0d last=%0d want 2/0/1", beats, first, lastc);
        end
        checks++;
        if (rec_count !== 16'(exp_rec)) begin
            failures++;
            $display("FAIL sp_rec: got %0d want %0d", rec_count, exp_rec);
        end
    endtask

    task automatic test_backpressure();
        beat_t e;
        int    beats;
        int    stall;
        beats = 0;
        stall = 0;
        @(posedge clk);
        #1;
        rand_fields();
        in_mask   = 4'hF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        push_record(in_mask);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            rand_fields();
            out_ready = (stall == 2);
            #1;
            if (out_valid && exp_q.size() != 0) begin
                checks++;
                if (out_data !== exp_q[0].data || out_lane !== exp_q[0].lane) begin
                    failures++;
                    $display("FAIL bp_hold: got lane=%0d data=%h want lane=%0d data=%h",
                             out_lane, out_data, exp_q[0].lane, exp_q[0].data);
                end
                checks++;
                if (in_ready !== (exp_q[0].last && out_ready)) begin
                    failures++;
                    $display("FAIL bp_in_ready: got %b want %b", in_ready, exp_q[0].last && out_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                beats++;
                stall = 0;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_beat: unexpected beat lane=%0d data=%h", out_lane, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_lane, out_data, out_last} !== {e.lane, e.data, e.last}) begin
                        failures++;
                        $display("FAIL bp_beat: got lane=%0d data=%h last=%b want lane=%0d data=%h last=%b",
                                 out_lane, out_data, out_last, e.lane, e.data, e.last);
                    end
                    if (e.last) exp_rec++;
                end
            end else if (out_valid) begin
                stall++;
            end
        end
        out_ready = 1'b1;
        checks++;
        if (beats != 4) begin
            failures++;
            $display("FAIL bp_count: got %0d beats want 4", beats);
        end
        checks++;
        if (rec_count !== 16'(exp_rec)) begin
            failures++;
            $display("FAIL bp_rec: got %0d want %0d", rec_count, exp_rec);
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        int    beats;
        int    n_acc;
        int    acc2;
        int    beat_c[8];
        beats = 0;
        n_acc = 1;
        acc2  = -1;
        @(posedge clk);
        #1;
        rand_fields();
        in_mask   = 4'hF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        push_record(in_mask);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) rand_fields();
            if (n_acc == 2) begin
                in_valid = 1'b0;
                rand_fields();
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (beats < 8) beat_c[beats] = c;
                beats++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bb_beat: unexpected beat lane=%0d data=%h", out_lane, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_lane, out_data, out_last} !== {e.lane, e.data, e.last}) begin
                        failures++;
                        $display("FAIL bb_beat: got lane=%0d data=%h last=%b want lane=%0d data=%h last=%b",
                                 out_lane, out_data, out_last, e.lane, e.data, e.last);
                    end
                    if (e.last) exp_rec++;
                end
            end
            if (in_valid && in_ready) begin
                push_record(in_mask);
                n_acc++;
                acc2 = c;
            end
        end
        checks++;
        if (beats != 8) begin
            failures++;
            $display("FAIL bb_count: got %0d beats want 8", beats);
        end else begin
            checks++;
            if (beat_c[0] != 0 || beat_c[7] != 7) begin
                failures++;
                $display("FAIL bb_contig: got first=%0d last=%0d want 0/7", beat_c[0], beat_c[7]);
            end
            checks++;
            if (acc2 != beat_c[3]) begin
                failures++;
                $display("FAIL bb_accept2: got cycle %0d want %0d", acc2, beat_c[3]);
            end
        end
        checks++;
        if (rec_count !== 16'(exp_rec)) begin
            failures++;
            $display("FAIL bb_rec: got %0d want %0d", rec_count, exp_rec);
        end
    endtask

`ifdef PACKER144_PARITY_EN
    task automatic test_parity();
        beat_t e;
        int    beats;
        beats = 0;
        @(posedge clk);
        #1;
        f0 = 4'h0; f1 = 32'h0000_000F; f2 = 4'h0; f3 = 32'h0;
        f4 = 32'h0; f5 = 8'h0; f6 = 32'h0;
        in_mask   = 4'hF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        push_record(in_mask);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            #1;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                checks++;
                beats++;
                e = exp_q.pop_front();
                if (out_parity !== 1'b1 || out_data !== e.data) begin
                    failures++;
                    $display("FAIL par_beat: got parity=%b data=%h want 1/%h", out_parity, out_data, e.data);
                end
                if (e.last) exp_rec++;
            end
        end
        checks++;
        if (beats != 4) begin
            failures++;
            $display("FAIL par_count: got %0d beats want 4", beats);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mask_zero_reset();
        test_lane_map();
        test_sparse();
        test_backpressure();
        test_back_to_back();
`ifdef PACKER144_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: got %0d pending beats want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/packer144.md
# packer144

Transmit-side counterpart of the 144-bit lane splitter used in the visualization path. It accepts one wide 4-thread record as seven bit-interleaved fields with widths (4, 32, 4, 32, 32, 8, 32). It de-interleaves the record into four 36-bit per-lane words with field layout (1, 8, 1, 8, 8, 2, 8), low to high. It then serializes the selected lanes one word per beat over a single valid/ready stream, so the per-lane trace stays narrow.

## Interface
- No parameters; all widths fixed.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  record present.
- in_ready  out  1  record accepted on the edge where in_valid && in_ready.
- in_mask  in  4  lane enable, sampled with the record; bit k=1 sends lane k.
- f0  in  4  field0, bit k = lane k.
- f1  in  32  field1, bit 4j+k = lane k bit j.
- f2  in  4  field2, bit k = lane k.
- f3  in  32  field3, interleaved as for f1.
- f4  in  32  field4, interleaved as for f1.
- f5  in  8  field5, bit 4j+k = lane k bit j, j=0..1.
- f6  in  32  field6, interleaved as for f1.
- out_valid  out  1  beat present.
- out_ready  in  1  beat consumed on the edge where out_valid && out_ready.
- out_data  out  36  lane word.
- out_lane  out  2  lane index of out_data.
- out_last  out  1  final beat of the record.
- rec_count  out  16  records fully emitted, wraps at 0xFFFF→0.

## Operation
- Lane k word layout:
  - bit0 = f0[k]
  - [8:1] bit j = f1[4j+k]
  - bit9 = f2[k]
  - [17:10] bit j = f3[4j+k]
  - [25:18] bit j = f4[4j+k]
  - [27:26] bit j = f5[4j+k]
  - [35:28] bit j = f6[4j+k]
- On accept, all four lane words and the mask are latched into a 148-bit holding register. Input fields may change afterwards without effect.
- FSM states:
  - IDLE: out_valid=0, in_ready=1.
    - Accept with in_mask≠0 → SEND; out_lane = lowest set mask bit.
    - Accept with in_mask=0 → record consumed and discarded; stay IDLE; rec_count unchanged.
  - SEND: out_valid=1; out_data = held word[out_lane].
    - out_last=1 iff no mask bit above out_lane is set.
    - Beat consumed, not last → out_lane advances to the next set mask bit; skipped lanes cost no cycles.
    - Beat consumed, last → rec_count+1. Then go to IDLE, or take a new record in the same cycle (see Timing).
- in_ready = reset_n && (IDLE || (SEND && out_last && out_ready)).
  - When a record is accepted on the last-beat edge, it follows with no bubble. Mask=0 records accepted there are discarded, and the FSM returns to IDLE.
- While out_valid && !out_ready: out_data, out_lane and out_last are held stable.

## Timing
- Reset (reset_n low at an edge):
  - state=IDLE, out_valid=0, out_data=0, out_lane=0, out_last=0, rec_count=0.
  - in_ready=0 combinationally while reset_n is low.
- Reset mid-record drops the record. rec_count does not count it.
- Latency: record accepted at edge N → first beat valid in the cycle after edge N.
- Throughput: mask with p set bits → p cycles per record under continuous out_ready, back-to-back.
- All outputs are registered except in_ready (combinational from state, out_last, out_ready, reset_n).

## Configuration
- PACKER144_PARITY_EN defined:
  - Adds output port out_parity (1 bit), registered with out_data, equal to XOR of out_data[35:0].
  - Reset value 0; held with out_data under backpressure.
- Not defined: the port is absent and there is no parity logic; all other behaviour is identical.

## Test plan
- Lane mapping, mask=4'hF, f0=4'b0101, f6=32'hF000_0000, all other fields 0, out_ready=1.
  - Expect beats lane0..3: 36'h8_0000_0001, 36'h8_0000_0000, 36'h8_0000_0001, 36'h8_0000_0000.
  - out_last only on lane3; rec_count=1.
- Sparse mask=4'b1010, f1=32'hFFFF_FFFF.
  - Expect exactly two consecutive beats: lane1 then lane3, each out_data=36'h0_0000_01FE.
  - out_last on lane3.
- Backpressure: out_ready toggles 0,0,1 per beat, mask=4'hF.
  - out_data/out_lane stable through stalls; exactly 4 beats; in_ready=0 until the last-beat handshake.
- Back-to-back: two mask=4'hF records, in_valid held, out_ready=1.
  - 8 contiguous beats, no idle cycle; second accept on the edge of beat 4; rec_count=2.
- Mask=0 and reset: mask=0 record → in_ready=1, no beats, rec_count=0.
  - Then start a mask=4'hF record and drop reset_n after beat 1.
  - Next cycle: out_valid=0, rec_count=0, in_ready=0 until reset_n is high.
- With PACKER144_PARITY_EN:
  - First scenario → out_parity = 0, 1, 0, 1.
  - f1=32'h0000_000F, mask=4'hF → out_parity=1 on every lane.
